// File: rtl/writeback_pkg.sv
// writeback_pkg: shared types for the register-file writeback arbiter
package writeback_pkg;
  typedef logic [4:0]  regbits_t;
  typedef logic [31:0] word_t;
  typedef struct packed {
    logic     live;
    regbits_t wsel;
    word_t    wdat;
  } wb_entry_t;
endpackage

// File: rtl/writeback_arbiter_fifo.sv
// wb_fifo: long-latency result queue with per-entry WAW squash
//  i_clk/i_nrst      clock, async active-low reset
//  i_push/i_entry    enqueue an entry (ignored when full)
//  i_pop             dequeue the head (ignored when empty)
//  i_squash/_sel     clear live on every entry (incl. one pushed now) with wsel==sel
//  o_head            head entry; o_full/o_empty status
//  o_mem/o_occ       raw entry storage and occupancy, for hazard lookups
module wb_fifo
  import writeback_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  i_clk,
  input  logic                  i_nrst,
  input  logic                  i_push,
  input  wb_entry_t             i_entry,
  input  logic                  i_pop,
  input  logic                  i_squash,
  input  regbits_t              i_squash_sel,
  output wb_entry_t             o_head,
  output logic                  o_full,
  output logic                  o_empty,
  output wb_entry_t [DEPTH-1:0] o_mem,
  output logic      [DEPTH-1:0] o_occ
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic      [PW-1:0]    r_rd, r_wr;
  logic      [CW-1:0]    r_cnt;
  wb_entry_t [DEPTH-1:0] r_mem;
  logic      [DEPTH-1:0] r_occ;
  logic                  w_push, w_pop;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  assign o_full  = r_cnt == CW'(DEPTH);
  assign o_empty = r_cnt == '0;
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_head  = r_mem[r_rd];
  assign o_mem   = r_mem;
  assign o_occ   = r_occ;
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
      r_mem <= '0;
      r_occ <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (i_squash && r_mem[i].wsel == i_squash_sel) r_mem[i].live <= 1'b0;
      // the pushed slot is empty, so its write never collides with the pop slot
      if (w_push) begin
        r_mem[r_wr] <= '{live: i_entry.live & ~(i_squash && i_entry.wsel == i_squash_sel),
                         wsel: i_entry.wsel, wdat: i_entry.wdat};
        r_occ[r_wr] <= 1'b1;
        r_wr        <= inc(r_wr);
      end
      if (w_pop) begin
        r_occ[r_rd] <= 1'b0;
        r_rd        <= inc(r_rd);
      end
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end
endmodule

// File: rtl/writeback_arbiter.sv
// writeback_arbiter: merges pipeline WB and long-latency results onto one RF write port
//  i_clk/i_nrst            clock, async active-low reset
//  i_pl_wen/_wsel/_wdat    pipeline write request (wsel 0 means no request)
//  i_ll_valid/o_ll_ready   long-latency handshake; i_ll_wsel/_wdat its result
//  o_stall_req             buffer full, pipeline must not write next cycle
//  i_qsel1/2, o_busy1/2    hazard query: register has a queued live write
//  o_rf_wen/_wsel/_wdat    registered register-file write port
module writeback_arbiter
  import writeback_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic     i_clk,
  input  logic     i_nrst,
  input  logic     i_pl_wen,
  input  regbits_t i_pl_wsel,
  input  word_t    i_pl_wdat,
  input  logic     i_ll_valid,
  output logic     o_ll_ready,
  input  regbits_t i_ll_wsel,
  input  word_t    i_ll_wdat,
  output logic     o_stall_req,
  input  regbits_t i_qsel1,
  input  regbits_t i_qsel2,
  output logic     o_busy1,
  output logic     o_busy2,
  output logic     o_rf_wen,
  output regbits_t o_rf_wsel,
  output word_t    o_rf_wdat
);
  wb_entry_t             w_head;
  wb_entry_t             w_ll_entry;
  wb_entry_t [DEPTH-1:0] w_mem;
  logic      [DEPTH-1:0] w_occ;
  logic                  w_full, w_empty, w_pl_req, w_pop;
  logic                  r_rf_wen;
  regbits_t              r_rf_wsel;
  word_t                 r_rf_wdat;
  assign w_pl_req    = i_pl_wen && i_pl_wsel != '0;
  assign w_pop       = ~w_pl_req & ~w_empty;
  // writes to $zero are queued as dead entries so the handshake still completes
  assign w_ll_entry  = '{live: i_ll_wsel != '0, wsel: i_ll_wsel, wdat: i_ll_wdat};
  assign o_ll_ready  = ~w_full;
  assign o_stall_req = w_full;
  assign o_rf_wen    = r_rf_wen;
  assign o_rf_wsel   = r_rf_wsel;
  assign o_rf_wdat   = r_rf_wdat;
  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk       (i_clk),
    .i_nrst      (i_nrst),
    .i_push      (i_ll_valid & o_ll_ready),
    .i_entry     (w_ll_entry),
    .i_pop       (w_pop),
    .i_squash    (w_pl_req),
    .i_squash_sel(i_pl_wsel),
    .o_head      (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_mem       (w_mem),
    .o_occ       (w_occ)
  );
  always_comb begin
    o_busy1 = 1'b0;
    o_busy2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      o_busy1 = o_busy1 | (w_occ[i] & w_mem[i].live & (w_mem[i].wsel == i_qsel1));
      o_busy2 = o_busy2 | (w_occ[i] & w_mem[i].live & (w_mem[i].wsel == i_qsel2));
    end
    o_busy1 = o_busy1 & (i_qsel1 != '0);
    o_busy2 = o_busy2 & (i_qsel2 != '0);
  end
  // a popped dead entry still loads its fields but leaves the write disabled
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_rf_wen  <= 1'b0;
      r_rf_wsel <= '0;
      r_rf_wdat <= '0;
    end else begin
      r_rf_wen <= w_pl_req | (w_pop & w_head.live);
      if (w_pl_req) begin
        r_rf_wsel <= i_pl_wsel;
        r_rf_wdat <= i_pl_wdat;
      end else if (w_pop) begin
        r_rf_wsel <= w_head.wsel;
        r_rf_wdat <= w_head.wdat;
      end
    end
  end
endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter: directed vector table plus reset sequences for writeback_arbiter
module tb_writeback_arbiter;
  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        pl_wen, ll_valid;
  logic [4:0]  pl_wsel, ll_wsel, qsel1, qsel2;
  logic [31:0] pl_wdat, ll_wdat;
  logic        ll_ready, stall_req, busy1, busy2, rf_wen;
  logic [4:0]  rf_wsel;
  logic [31:0] rf_wdat;
  logic [31:0] rf_model [32];
  int          n_vec = 0;
  int          n_mis = 0;

  typedef struct {
    logic pl_wen; logic [4:0] pl_wsel; logic [31:0] pl_wdat;
    logic ll_valid; logic [4:0] ll_wsel; logic [31:0] ll_wdat;
    logic [4:0] q1, q2;
    logic e_wen; logic [4:0] e_wsel; logic [31:0] e_wdat;
    logic e_rdy, e_stall, e_b1, e_b2;
  } vec_t;
  vec_t vt [22];

  writeback_arbiter dut (
    .i_clk(clk), .i_nrst(nrst),
    .i_pl_wen(pl_wen), .i_pl_wsel(pl_wsel), .i_pl_wdat(pl_wdat),
    .i_ll_valid(ll_valid), .o_ll_ready(ll_ready), .i_ll_wsel(ll_wsel), .i_ll_wdat(ll_wdat),
    .o_stall_req(stall_req),
    .i_qsel1(qsel1), .i_qsel2(qsel2), .o_busy1(busy1), .o_busy2(busy2),
    .o_rf_wen(rf_wen), .o_rf_wsel(rf_wsel), .o_rf_wdat(rf_wdat)
  );

  always #5 clk = ~clk;

  // register file model fed by the write port
  always @(negedge clk)
    if (rf_wen && rf_wsel != 5'd0) rf_model[rf_wsel] = rf_wdat;

  // pipeline must not write while the buffer is full
  always @(posedge clk)
    if (nrst && pl_wen && pl_wsel != 5'd0 && stall_req) begin
      n_mis++;
      $display("FAIL contract: pl_wen=1 while stall_req=1");
    end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic pw, input logic [4:0] ps, input logic [31:0] pd,
                              input logic lv, input logic [4:0] ls, input logic [31:0] ld,
                              input logic [4:0] q1, input logic [4:0] q2,
                              input logic ew, input logic [4:0] es, input logic [31:0] ed,
                              input logic er, input logic est, input logic b1, input logic b2);
    vec_t v;
    v.pl_wen = pw; v.pl_wsel = ps; v.pl_wdat = pd;
    v.ll_valid = lv; v.ll_wsel = ls; v.ll_wdat = ld;
    v.q1 = q1; v.q2 = q2;
    v.e_wen = ew; v.e_wsel = es; v.e_wdat = ed;
    v.e_rdy = er; v.e_stall = est; v.e_b1 = b1; v.e_b2 = b2;
    return v;
  endfunction

  task automatic drive(input logic pw, input logic [4:0] ps, input logic [31:0] pd,
                       input logic lv, input logic [4:0] ls, input logic [31:0] ld);
    pl_wen = pw; pl_wsel = ps; pl_wdat = pd;
    ll_valid = lv; ll_wsel = ls; ll_wdat = ld;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf_model[i] = 32'd0;
    //          pl            ll                q       rf              rdy stl b1 b2
    vt[0]  = mk(1, 5, 4721,  0, 0, 0,         0, 0,   1, 5, 4721,     1, 0, 0, 0);
    vt[1]  = mk(0, 0, 0,     0, 0, 0,         0, 0,   0, 5, 4721,     1, 0, 0, 0);
    vt[2]  = mk(1, 3, 100,   1, 9, 25119,     9, 3,   1, 3, 100,      1, 0, 1, 0);
    vt[3]  = mk(1, 3, 101,   0, 0, 0,         9, 3,   1, 3, 101,      1, 0, 1, 0);
    vt[4]  = mk(1, 3, 102,   0, 0, 0,         9, 3,   1, 3, 102,      1, 0, 1, 0);
    vt[5]  = mk(0, 0, 0,     0, 0, 0,         9, 3,   1, 9, 25119,    1, 0, 0, 0);
    vt[6]  = mk(0, 0, 0,     0, 0, 0,         9, 0,   0, 9, 25119,    1, 0, 0, 0);
    vt[7]  = mk(1, 4, 200,   1, 10, 1000,     10, 11, 1, 4, 200,      1, 0, 1, 0);
    vt[8]  = mk(1, 4, 201,   1, 11, 1100,     10, 11, 1, 4, 201,      0, 1, 1, 1);
    vt[9]  = mk(0, 0, 0,     1, 12, 1200,     11, 12, 1, 10, 1000,    1, 0, 1, 0);
    vt[10] = mk(0, 0, 0,     0, 0, 0,         11, 12, 1, 11, 1100,    1, 0, 0, 0);
    vt[11] = mk(1, 2, 300,   1, 13, 1300,     13, 0,  1, 2, 300,      1, 0, 1, 0);
    vt[12] = mk(0, 0, 0,     1, 14, 1400,     13, 14, 1, 13, 1300,    1, 0, 0, 1);
    vt[13] = mk(0, 0, 0,     0, 0, 0,         14, 0,  1, 14, 1400,    1, 0, 0, 0);
    vt[14] = mk(1, 2, 301,   1, 7, 1,         7, 0,   1, 2, 301,      1, 0, 1, 0);
    vt[15] = mk(1, 7, 4721,  0, 0, 0,         7, 0,   1, 7, 4721,     1, 0, 0, 0);
    vt[16] = mk(0, 0, 0,     0, 0, 0,         7, 0,   0, 7, 1,        1, 0, 0, 0);
    vt[17] = mk(1, 8, 500,   1, 8, 77,        8, 0,   1, 8, 500,      1, 0, 0, 0);
    vt[18] = mk(0, 0, 0,     0, 0, 0,         8, 0,   0, 8, 77,       1, 0, 0, 0);
    vt[19] = mk(0, 0, 0,     1, 0, 55,        0, 0,   0, 8, 77,       1, 0, 0, 0);
    vt[20] = mk(0, 0, 0,     0, 0, 0,         0, 0,   0, 0, 55,       1, 0, 0, 0);
    vt[21] = mk(1, 0, 999,   0, 0, 0,         0, 0,   0, 0, 55,       1, 0, 0, 0);

    // reset held with a pipeline write pending
    drive(1, 1, 11, 0, 0, 0);
    qsel1 = 5'd0; qsel2 = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst rf_wen", 32'(rf_wen), 0);
    chk("rst rf_wsel", 32'(rf_wsel), 0);
    chk("rst rf_wdat", rf_wdat, 0);
    chk("rst ll_ready", 32'(ll_ready), 1);
    chk("rst stall_req", 32'(stall_req), 0);
    chk("rst busy1", 32'(busy1), 0);
    chk("rst busy2", 32'(busy2), 0);
    @(negedge clk) nrst = 1'b1;
    @(posedge clk) #1;
    chk("post-rst rf_wen", 32'(rf_wen), 1);
    chk("post-rst rf_wsel", 32'(rf_wsel), 1);
    chk("post-rst rf_wdat", rf_wdat, 11);

    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      drive(vt[i].pl_wen, vt[i].pl_wsel, vt[i].pl_wdat, vt[i].ll_valid, vt[i].ll_wsel, vt[i].ll_wdat);
      qsel1 = vt[i].q1; qsel2 = vt[i].q2;
      @(posedge clk) #1;
      chk($sformatf("v%0d rf_wen", i), 32'(rf_wen), 32'(vt[i].e_wen));
      chk($sformatf("v%0d rf_wsel", i), 32'(rf_wsel), 32'(vt[i].e_wsel));
      chk($sformatf("v%0d rf_wdat", i), rf_wdat, vt[i].e_wdat);
      chk($sformatf("v%0d ll_ready", i), 32'(ll_ready), 32'(vt[i].e_rdy));
      chk($sformatf("v%0d stall_req", i), 32'(stall_req), 32'(vt[i].e_stall));
      chk($sformatf("v%0d busy1", i), 32'(busy1), 32'(vt[i].e_b1));
      chk($sformatf("v%0d busy2", i), 32'(busy2), 32'(vt[i].e_b2));
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rf r5", rf_model[5], 4721);
    chk("rf r3", rf_model[3], 102);
    chk("rf r9", rf_model[9], 25119);
    chk("rf r7 younger wins", rf_model[7], 4721);
    chk("rf r8 same-edge squash", rf_model[8], 500);

    // fill the buffer, then reset mid-operation
    drive(1, 6, 600, 1, 20, 2000);
    @(negedge clk);
    drive(1, 6, 601, 1, 21, 2100);
    @(posedge clk) #1;
    chk("fill stall_req", 32'(stall_req), 1);
    chk("fill ll_ready", 32'(ll_ready), 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    qsel1 = 5'd20; qsel2 = 5'd21;
    #1;
    chk("fill busy1", 32'(busy1), 1);
    chk("fill busy2", 32'(busy2), 1);
    #1 nrst = 1'b0;
    #1;
    chk("midrst ll_ready", 32'(ll_ready), 1);
    chk("midrst stall_req", 32'(stall_req), 0);
    chk("midrst busy1", 32'(busy1), 0);
    chk("midrst busy2", 32'(busy2), 0);
    chk("midrst rf_wen", 32'(rf_wen), 0);
    @(negedge clk) nrst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk) #1;
      chk($sformatf("drain-after-rst%0d rf_wen", i), 32'(rf_wen), 0);
      chk($sformatf("drain-after-rst%0d ll_ready", i), 32'(ll_ready), 1);
    end
    @(negedge clk);
    chk("rf r20 discarded", rf_model[20], 0);
    chk("rf r21 discarded", rf_model[21], 0);
    chk("rf r6", rf_model[6], 601);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
